reg_scoreboard: RTL and testbench



---
 rtl/calc3_sb_pkg.sv | 13 +
 rtl/sb_hazard_check.sv | 25 ++
 rtl/reg_scoreboard.sv | 147 ++++++++++++++
 tb/tb_reg_scoreboard.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/calc3_sb_pkg.sv
// Shared constants and types for the calc3 register scoreboard.
package calc3_sb_pkg;

    localparam int unsigned DEF_ADR_W    = 4;
    localparam int unsigned DEF_NUM_REGS = 16;
    localparam int unsigned DEF_OUT_W    = DEF_ADR_W + 1;

    typedef enum logic {
        REQ_ADDER = 1'b0,
        REQ_SHIFT = 1'b1
    } req_e;

endpackage

// File: rtl/sb_hazard_check.sv
// Combinational RAW/WAW eligibility check for one issue requester.
// The busy vector it receives is already bypass-adjusted by the caller.
module sb_hazard_check #(
    parameter int unsigned ADR_W    = 4,
    parameter int unsigned NUM_REGS = 16
) (
    input  logic                req,
    input  logic                reset,
    input  logic [0:ADR_W-1]    src1,
    input  logic                src1_valid,
    input  logic [0:ADR_W-1]    src2,
    input  logic                src2_valid,
    input  logic [0:ADR_W-1]    dest,
    input  logic [NUM_REGS-1:0] busy,
    output logic                eligible
);

    always_comb begin
        eligible = req && !reset
                && !(src1_valid && busy[src1])
                && !(src2_valid && busy[src2])
                && !busy[dest];
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-side hazard scoreboard for the calc3 register file.
// Optional same-cycle writeback forwarding: define SCOREBOARD_BYPASS_EN.
module reg_scoreboard
    import calc3_sb_pkg::*;
#(
    parameter int unsigned ADR_W    = DEF_ADR_W,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS
) (
    input  logic                c_clk,
    input  logic                reset,
    input  logic                adder_issue_req,
    input  logic [0:ADR_W-1]    adder_issue_src1,
    input  logic [0:ADR_W-1]    adder_issue_src2,
    input  logic                adder_issue_src1_valid,
    input  logic                adder_issue_src2_valid,
    input  logic [0:ADR_W-1]    adder_issue_dest,
    output logic                adder_issue_gnt,
    input  logic                shift_issue_req,
    input  logic [0:ADR_W-1]    shift_issue_src1,
    input  logic [0:ADR_W-1]    shift_issue_src2,
    input  logic                shift_issue_src1_valid,
    input  logic                shift_issue_src2_valid,
    input  logic [0:ADR_W-1]    shift_issue_dest,
    output logic                shift_issue_gnt,
    input  logic                adder_write_valid,
    input  logic [0:ADR_W-1]    adder_write_adr,
    input  logic                shift_write_valid,
    input  logic [0:ADR_W-1]    shift_write_adr,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [ADR_W:0]      outstanding,
    output logic                wb_error
);

    localparam int unsigned OUT_W = ADR_W + 1;

    function automatic logic [OUT_W-1:0] popcount(input logic [NUM_REGS-1:0] v);
        logic [OUT_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            n = n + OUT_W'(v[i]);
        end
        return n;
    endfunction

    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] clr_hit;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] busy_chk;
    logic [NUM_REGS-1:0] busy_d;
    logic [OUT_W-1:0]    out_d;
    logic                err_d;
    logic                elig_a;
    logic                elig_s;
    logic                conflict;
    req_e                rr_q;
    req_e                rr_d;

    // Writeback clears; ignored while reset is asserted.
    always_comb begin
        clr_mask = '0;
        if (!reset) begin
            if (adder_write_valid) clr_mask[adder_write_adr] = 1'b1;
            if (shift_write_valid) clr_mask[shift_write_adr] = 1'b1;
        end
        clr_hit = clr_mask & busy_vec;
    end

`ifdef SCOREBOARD_BYPASS_EN
    always_comb busy_chk = busy_vec & ~clr_mask;
`else
    always_comb busy_chk = busy_vec;
`endif

    sb_hazard_check #(.ADR_W(ADR_W), .NUM_REGS(NUM_REGS)) u_chk_adder (
        .req        (adder_issue_req),
        .reset      (reset),
        .src1       (adder_issue_src1),
        .src1_valid (adder_issue_src1_valid),
        .src2       (adder_issue_src2),
        .src2_valid (adder_issue_src2_valid),
        .dest       (adder_issue_dest),
        .busy       (busy_chk),
        .eligible   (elig_a)
    );

    sb_hazard_check #(.ADR_W(ADR_W), .NUM_REGS(NUM_REGS)) u_chk_shift (
        .req        (shift_issue_req),
        .reset      (reset),
        .src1       (shift_issue_src1),
        .src1_valid (shift_issue_src1_valid),
        .src2       (shift_issue_src2),
        .src2_valid (shift_issue_src2_valid),
        .dest       (shift_issue_dest),
        .busy       (busy_chk),
        .eligible   (elig_s)
    );

    // Cross-path hazard between two same-cycle issues; rr picks the winner.
    always_comb begin
        rr_d            = rr_q;
        adder_issue_gnt = 1'b0;
        shift_issue_gnt = 1'b0;
        conflict = elig_a && elig_s &&
                   ((adder_issue_dest == shift_issue_dest)
                 || (shift_issue_src1_valid && (adder_issue_dest == shift_issue_src1))
                 || (shift_issue_src2_valid && (adder_issue_dest == shift_issue_src2))
                 || (adder_issue_src1_valid && (shift_issue_dest == adder_issue_src1))
                 || (adder_issue_src2_valid && (shift_issue_dest == adder_issue_src2)));
        if (conflict) begin
            adder_issue_gnt = (rr_q == REQ_ADDER);
            shift_issue_gnt = (rr_q == REQ_SHIFT);
            rr_d            = (rr_q == REQ_ADDER) ? REQ_SHIFT : REQ_ADDER;
        end else begin
            adder_issue_gnt = elig_a;
            shift_issue_gnt = elig_s;
        end
    end

    // Set wins over a same-cycle clear, so the +1/-1 pair nets to zero.
    always_comb begin
        set_mask = '0;
        if (adder_issue_gnt) set_mask[adder_issue_dest] = 1'b1;
        if (shift_issue_gnt) set_mask[shift_issue_dest] = 1'b1;
        busy_d = (busy_vec & ~clr_hit) | set_mask;
        out_d  = outstanding + popcount(set_mask) - popcount(clr_hit);
        err_d  = wb_error
              || (adder_write_valid && !busy_vec[adder_write_adr])
              || (shift_write_valid && !busy_vec[shift_write_adr])
              || (adder_write_valid && shift_write_valid
                  && (adder_write_adr == shift_write_adr));
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            rr_q        <= REQ_ADDER;
            busy_vec    <= '0;
            outstanding <= '0;
            wb_error    <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            busy_vec    <= busy_d;
            outstanding <= out_d;
            wb_error    <= err_d;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed table-driven bench for reg_scoreboard (default and bypass builds).
module tb_reg_scoreboard;

    logic        c_clk;
    logic        reset;
    logic        adder_issue_req;
    logic [0:3]  adder_issue_src1;
    logic [0:3]  adder_issue_src2;
    logic        adder_issue_src1_valid;
    logic        adder_issue_src2_valid;
    logic [0:3]  adder_issue_dest;
    logic        adder_issue_gnt;
    logic        shift_issue_req;
    logic [0:3]  shift_issue_src1;
    logic [0:3]  shift_issue_src2;
    logic        shift_issue_src1_valid;
    logic        shift_issue_src2_valid;
    logic [0:3]  shift_issue_dest;
    logic        shift_issue_gnt;
    logic        adder_write_valid;
    logic [0:3]  adder_write_adr;
    logic        shift_write_valid;
    logic [0:3]  shift_write_adr;
    logic [15:0] busy_vec;
    logic [4:0]  outstanding;
    logic        wb_error;

    int checks = 0;
    int errors = 0;

    reg_scoreboard dut (
        .c_clk                  (c_clk),
        .reset                  (reset),
        .adder_issue_req        (adder_issue_req),
        .adder_issue_src1       (adder_issue_src1),
        .adder_issue_src2       (adder_issue_src2),
        .adder_issue_src1_valid (adder_issue_src1_valid),
        .adder_issue_src2_valid (adder_issue_src2_valid),
        .adder_issue_dest       (adder_issue_dest),
        .adder_issue_gnt        (adder_issue_gnt),
        .shift_issue_req        (shift_issue_req),
        .shift_issue_src1       (shift_issue_src1),
        .shift_issue_src2       (shift_issue_src2),
        .shift_issue_src1_valid (shift_issue_src1_valid),
        .shift_issue_src2_valid (shift_issue_src2_valid),
        .shift_issue_dest       (shift_issue_dest),
        .shift_issue_gnt        (shift_issue_gnt),
        .adder_write_valid      (adder_write_valid),
        .adder_write_adr        (adder_write_adr),
        .shift_write_valid      (shift_write_valid),
        .shift_write_adr        (shift_write_adr),
        .busy_vec               (busy_vec),
        .outstanding            (outstanding),
        .wb_error               (wb_error)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    typedef struct {
        logic        rst;
        logic        ar;
        logic [0:3]  as1;
        logic        as1v;
        logic [0:3]  as2;
        logic        as2v;
        logic [0:3]  ad;
        logic        sr;
        logic [0:3]  ss1;
        logic        ss1v;
        logic [0:3]  ss2;
        logic        ss2v;
        logic [0:3]  sd;
        logic        awv;
        logic [0:3]  awa;
        logic        swv;
        logic [0:3]  swa;
        logic        e_ag;
        logic        e_sg;
        logic [15:0] e_busy;
        logic [4:0]  e_out;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Drive at negedge, check grants mid-cycle, check registered state after the edge.
    task automatic run_vec(input vec_t v, input int idx);
        @(negedge c_clk);
        reset                  = v.rst;
        adder_issue_req        = v.ar;
        adder_issue_src1       = v.as1;
        adder_issue_src1_valid = v.as1v;
        adder_issue_src2       = v.as2;
        adder_issue_src2_valid = v.as2v;
        adder_issue_dest       = v.ad;
        shift_issue_req        = v.sr;
        shift_issue_src1       = v.ss1;
        shift_issue_src1_valid = v.ss1v;
        shift_issue_src2       = v.ss2;
        shift_issue_src2_valid = v.ss2v;
        shift_issue_dest       = v.sd;
        adder_write_valid      = v.awv;
        adder_write_adr        = v.awa;
        shift_write_valid      = v.swv;
        shift_write_adr        = v.swa;
        #1;
        chk("adder_gnt", idx, 32'(adder_issue_gnt), 32'(v.e_ag));
        chk("shift_gnt", idx, 32'(shift_issue_gnt), 32'(v.e_sg));
        @(posedge c_clk);
        #1;
        chk("busy_vec", idx, 32'(busy_vec), 32'(v.e_busy));
        chk("outstanding", idx, 32'(outstanding), 32'(v.e_out));
        chk("wb_error", idx, 32'(wb_error), 32'(v.e_err));
    endtask

    initial begin
        reset = 1'b1;
        adder_issue_req = 1'b0; adder_issue_src1 = '0; adder_issue_src2 = '0;
        adder_issue_src1_valid = 1'b0; adder_issue_src2_valid = 1'b0; adder_issue_dest = '0;
        shift_issue_req = 1'b0; shift_issue_src1 = '0; shift_issue_src2 = '0;
        shift_issue_src1_valid = 1'b0; shift_issue_src2_valid = 1'b0; shift_issue_dest = '0;
        adder_write_valid = 1'b0; adder_write_adr = '0;
        shift_write_valid = 1'b0; shift_write_adr = '0;

        // rst | adder req,s1,v,s2,v,dest | shift req,s1,v,s2,v,dest | wbs | exp ag,sg,busy,out,err
        vecs.push_back('{1'b1, 1'b1,4'd0,1'b0,4'd0,1'b0,4'd0,  1'b1,4'd0,1'b0,4'd0,1'b0,4'd3,
                         1'b1,4'd3,1'b1,4'd4, 1'b0,1'b0,16'h0000,5'd0,1'b0});
        vecs.push_back('{1'b0, 1'b1,4'd2,1'b1,4'd3,1'b1,4'd5,  1'b0,4'd0,1'b0,4'd0,1'b0,4'd0,
                         1'b0,4'd0,1'b0,4'd0, 1'b1,1'b0,16'h0020,5'd1,1'b0});
        vecs.push_back('{1'b0, 1'b0,4'd0,1'b0,4'd0,1'b0,4'd0,  1'b1,4'd5,1'b1,4'd0,1'b0,4'd6,
                         1'b0,4'd0,1'b0,4'd0, 1'b0,1'b0,16'h0020,5'd1,1'b0});
        vecs.push_back('{1'b0, 1'b1,4'd0,1'b0,4'd0,1'b0,4'd7,  1'b1,4'd0,1'b0,4'd0,1'b0,4'd7,
                         1'b0,4'd0,1'b0,4'd0, 1'b1,1'b0,16'h00A0,5'd2,1'b0});
        vecs.push_back('{1'b0, 1'b1,4'd0,1'b0,4'd0,1'b0,4'd8,  1'b1,4'd0,1'b0,4'd0,1'b0,4'd8,
                         1'b0,4'd0,1'b0,4'd0, 1'b0,1'b1,16'h01A0,5'd3,1'b0});
        vecs.push_back('{1'b0, 1'b1,4'd0,1'b0,4'd0,1'b0,4'd4,  1'b1,4'd4,1'b1,4'd0,1'b0,4'd9,
                         1'b0,4'd0,1'b0,4'd0, 1'b1,1'b0,16'h01B0,5'd4,1'b0});
        vecs.push_back('{1'b0, 1'b1,4'd0,1'b0,4'd0,1'b0,4'd10, 1'b1,4'd10,1'b0,4'd0,1'b0,4'd11,
                         1'b0,4'd0,1'b0,4'd0, 1'b1,1'b1,16'h0DB0,5'd6,1'b0});
        vecs.push_back('{1'b0, 1'b1,4'd0,1'b0,4'd0,1'b0,4'd12, 1'b1,4'd0,1'b0,4'd0,1'b0,4'd12,
                         1'b0,4'd0,1'b0,4'd0, 1'b0,1'b1,16'h1DB0,5'd7,1'b0});
        vecs.push_back('{1'b0, 1'b0,4'd0,1'b0,4'd0,1'b0,4'd0,  1'b0,4'd0,1'b0,4'd0,1'b0,4'd0,
                         1'b1,4'd5,1'b0,4'd0, 1'b0,1'b0,16'h1D90,5'd6,1'b0});
        vecs.push_back('{1'b0, 1'b0,4'd0,1'b0,4'd0,1'b0,4'd0,  1'b0,4'd0,1'b0,4'd0,1'b0,4'd0,
                         1'b1,4'd9,1'b0,4'd0, 1'b0,1'b0,16'h1D90,5'd6,1'b1});
        vecs.push_back('{1'b0, 1'b0,4'd0,1'b0,4'd0,1'b0,4'd0,  1'b0,4'd0,1'b0,4'd0,1'b0,4'd0,
                         1'b0,4'd0,1'b0,4'd0, 1'b0,1'b0,16'h1D90,5'd6,1'b1});
        vecs.push_back('{1'b0, 1'b1,4'd0,1'b0,4'd0,1'b0,4'd1,  1'b0,4'd0,1'b0,4'd0,1'b0,4'd0,
                         1'b0,4'd0,1'b0,4'd0, 1'b1,1'b0,16'h1D92,5'd7,1'b1});
        vecs.push_back('{1'b0, 1'b0,4'd0,1'b0,4'd0,1'b0,4'd0,  1'b0,4'd0,1'b0,4'd0,1'b0,4'd0,
                         1'b1,4'd1,1'b1,4'd1, 1'b0,1'b0,16'h1D90,5'd6,1'b1});
        vecs.push_back('{1'b0, 1'b0,4'd0,1'b0,4'd0,1'b0,4'd0,  1'b0,4'd0,1'b0,4'd0,1'b0,4'd0,
                         1'b1,4'd8,1'b1,4'd7, 1'b0,1'b0,16'h1C10,5'd4,1'b1});
        vecs.push_back('{1'b0, 1'b1,4'd4,1'b1,4'd0,1'b0,4'd13, 1'b1,4'd0,1'b0,4'd0,1'b0,4'd10,
                         1'b0,4'd0,1'b0,4'd0, 1'b0,1'b0,16'h1C10,5'd4,1'b1});
        vecs.push_back('{1'b0, 1'b1,4'd0,1'b0,4'd14,1'b1,4'd13, 1'b1,4'd0,1'b0,4'd0,1'b0,4'd14,
                         1'b0,4'd0,1'b0,4'd0, 1'b1,1'b0,16'h3C10,5'd5,1'b1});

        // Shift waits on r4; writeback of r4 arrives in the second cycle.
        vecs.push_back('{1'b0, 1'b0,4'd0,1'b0,4'd0,1'b0,4'd0,  1'b1,4'd4,1'b1,4'd0,1'b0,4'd15,
                         1'b0,4'd0,1'b0,4'd0, 1'b0,1'b0,16'h3C10,5'd5,1'b1});
`ifdef SCOREBOARD_BYPASS_EN
        vecs.push_back('{1'b0, 1'b0,4'd0,1'b0,4'd0,1'b0,4'd0,  1'b1,4'd4,1'b1,4'd0,1'b0,4'd15,
                         1'b1,4'd4,1'b0,4'd0, 1'b0,1'b1,16'hBC00,5'd5,1'b1});
        vecs.push_back('{1'b0, 1'b0,4'd0,1'b0,4'd0,1'b0,4'd0,  1'b1,4'd4,1'b1,4'd0,1'b0,4'd15,
                         1'b0,4'd0,1'b0,4'd0, 1'b0,1'b0,16'hBC00,5'd5,1'b1});
        vecs.push_back('{1'b0, 1'b1,4'd0,1'b0,4'd0,1'b0,4'd10, 1'b0,4'd0,1'b0,4'd0,1'b0,4'd0,
                         1'b0,4'd0,1'b1,4'd10, 1'b1,1'b0,16'hBC00,5'd5,1'b1});
`else
        vecs.push_back('{1'b0, 1'b0,4'd0,1'b0,4'd0,1'b0,4'd0,  1'b1,4'd4,1'b1,4'd0,1'b0,4'd15,
                         1'b1,4'd4,1'b0,4'd0, 1'b0,1'b0,16'h3C00,5'd4,1'b1});
        vecs.push_back('{1'b0, 1'b0,4'd0,1'b0,4'd0,1'b0,4'd0,  1'b1,4'd4,1'b1,4'd0,1'b0,4'd15,
                         1'b0,4'd0,1'b0,4'd0, 1'b0,1'b1,16'hBC00,5'd5,1'b1});
        vecs.push_back('{1'b0, 1'b1,4'd0,1'b0,4'd0,1'b0,4'd10, 1'b0,4'd0,1'b0,4'd0,1'b0,4'd0,
                         1'b0,4'd0,1'b1,4'd10, 1'b0,1'b0,16'hB800,5'd4,1'b1});
`endif

        // Reset mid-operation with stray requests and a writeback, then rr back at adder.
        vecs.push_back('{1'b1, 1'b1,4'd0,1'b0,4'd0,1'b0,4'd0,  1'b1,4'd0,1'b0,4'd0,1'b0,4'd2,
                         1'b1,4'd11,1'b0,4'd0, 1'b0,1'b0,16'h0000,5'd0,1'b0});
        vecs.push_back('{1'b0, 1'b1,4'd2,1'b1,4'd3,1'b1,4'd5,  1'b0,4'd0,1'b0,4'd0,1'b0,4'd0,
                         1'b0,4'd0,1'b0,4'd0, 1'b1,1'b0,16'h0020,5'd1,1'b0});
        vecs.push_back('{1'b0, 1'b1,4'd0,1'b0,4'd0,1'b0,4'd7,  1'b1,4'd0,1'b0,4'd0,1'b0,4'd7,
                         1'b0,4'd0,1'b0,4'd0, 1'b1,1'b0,16'h00A0,5'd2,1'b0});

        foreach (vecs[i]) run_vec(vecs[i], i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
